// File: rtl/sdram_wr_arb_pkg.sv
// Shared types and defaults for the SDRAM write-port arbiter and its datapath mux.
// The package holds no logic, so it adds no latency and has no backpressure of its own.
package sdram_wr_arb_pkg;

    typedef enum logic [1:0] {
        IDLE  = 2'd0,
        OWN_A = 2'd1,
        OWN_B = 2'd2
    } state_t;

    localparam logic SEL_A = 1'b0;
    localparam logic SEL_B = 1'b1;

    localparam int DATA_W_DEF    = 16;
    localparam int ADDR_W_DEF    = 19;
    localparam int MAX_BURST_DEF = 64;

endpackage

// File: rtl/sdram_write_mux.sv
// 2:1 write-path mux steered by the registered select; it is combinational with zero latency.
// The enable is gated by grant, so a non-owner beat never reaches the controller.
module sdram_write_mux
    import sdram_wr_arb_pkg::*;
#(
    parameter int DATA_W = DATA_W_DEF,
    parameter int ADDR_W = ADDR_W_DEF
) (
    input  logic              i_sel,
    input  logic              i_grantA,
    input  logic              i_grantB,
    input  logic [DATA_W-1:0] i_dataA,
    input  logic [DATA_W-1:0] i_dataB,
    input  logic [ADDR_W-1:0] i_addrA,
    input  logic [ADDR_W-1:0] i_addrB,
    input  logic              i_enableWriteA,
    input  logic              i_enableWriteB,
    output logic [DATA_W-1:0] o_data,
    output logic [ADDR_W-1:0] o_addr,
    output logic              o_enableWrite
);

    always_comb begin
        if (i_sel == SEL_B) begin
            o_data        = i_dataB;
            o_addr        = i_addrB;
            o_enableWrite = i_grantB & i_enableWriteB;
        end else begin
            o_data        = i_dataA;
            o_addr        = i_addrA;
            o_enableWrite = i_grantA & i_enableWriteA;
        end
    end

endmodule

// File: rtl/sdram_write_arbiter.sv
// Two-requester SDRAM write arbiter: the grant follows one cycle after a request, bursts are capped at MAX_BURST, and owner changes always pass through IDLE.
// i_sdramReady low stalls the owner with no timeout. SDRAM_WR_ARB_PRIO_A_EN selects strict A priority instead of round robin.
module sdram_write_arbiter
    import sdram_wr_arb_pkg::*;
#(
    parameter int DATA_W    = DATA_W_DEF,
    parameter int ADDR_W    = ADDR_W_DEF,
    parameter int MAX_BURST = MAX_BURST_DEF
) (
    input  logic              i_clk,
    input  logic              i_rst_n,
    input  logic              i_reqA,
    input  logic              i_reqB,
    input  logic [DATA_W-1:0] i_dataA,
    input  logic [DATA_W-1:0] i_dataB,
    input  logic [ADDR_W-1:0] i_addrA,
    input  logic [ADDR_W-1:0] i_addrB,
    input  logic              i_enableWriteA,
    input  logic              i_enableWriteB,
    input  logic              i_sdramReady,
    output logic              o_grantA,
    output logic              o_grantB,
    output logic              o_ackA,
    output logic              o_ackB,
    output logic              o_sel,
    output logic [DATA_W-1:0] o_data,
    output logic [ADDR_W-1:0] o_addr,
    output logic              o_enableWrite,
    output logic              o_busy
);

    localparam int               CNT_W     = $clog2(MAX_BURST) + 1;
    localparam logic [CNT_W-1:0] LAST_BEAT = CNT_W'(MAX_BURST - 1);

    state_t           r_state;
    state_t           w_state_nxt;
    logic [CNT_W-1:0] r_cnt;
    logic [CNT_W-1:0] w_cnt_nxt;
    logic             r_sel;
    logic             w_sel_nxt;
    logic             w_grantA;
    logic             w_grantB;
    logic             w_beatA;
    logic             w_beatB;
    logic             w_pickB;
`ifndef SDRAM_WR_ARB_PRIO_A_EN
    logic             r_last;
    logic             w_last_nxt;
`endif

    assign w_grantA = (r_state == OWN_A);
    assign w_grantB = (r_state == OWN_B);
    assign w_beatA  = w_grantA & i_enableWriteA & i_sdramReady;
    assign w_beatB  = w_grantB & i_enableWriteB & i_sdramReady;

    // B only wins a tie when A was the last owner; strict priority never lets B win one.
`ifdef SDRAM_WR_ARB_PRIO_A_EN
    assign w_pickB = i_reqB & ~i_reqA;
`else
    assign w_pickB = i_reqB & (~i_reqA | (r_last == SEL_A));
`endif

    always_comb begin
        w_state_nxt = r_state;
        w_cnt_nxt   = r_cnt;
        w_sel_nxt   = r_sel;
`ifndef SDRAM_WR_ARB_PRIO_A_EN
        w_last_nxt  = r_last;
`endif
        case (r_state)
            IDLE: begin
                if (w_pickB) begin
                    w_state_nxt = OWN_B;
                    w_sel_nxt   = SEL_B;
                end else if (i_reqA) begin
                    w_state_nxt = OWN_A;
                    w_sel_nxt   = SEL_A;
                end
            end
            OWN_A: begin
                if (!i_reqA || (w_beatA && (r_cnt == LAST_BEAT))) begin
                    w_state_nxt = IDLE;
                    w_cnt_nxt   = '0;
`ifndef SDRAM_WR_ARB_PRIO_A_EN
                    w_last_nxt  = SEL_A;
`endif
                end else if (w_beatA) begin
                    w_cnt_nxt = r_cnt + CNT_W'(1);
                end
            end
            OWN_B: begin
                if (!i_reqB || (w_beatB && (r_cnt == LAST_BEAT))) begin
                    w_state_nxt = IDLE;
                    w_cnt_nxt   = '0;
`ifndef SDRAM_WR_ARB_PRIO_A_EN
                    w_last_nxt  = SEL_B;
`endif
                end else if (w_beatB) begin
                    w_cnt_nxt = r_cnt + CNT_W'(1);
                end
            end
            default: begin
                w_state_nxt = IDLE;
                w_cnt_nxt   = '0;
            end
        endcase
    end

    always_ff @(posedge i_clk or negedge i_rst_n) begin
        if (!i_rst_n) begin
            r_state <= IDLE;
            r_cnt   <= '0;
            r_sel   <= SEL_A;
        end else begin
            r_state <= w_state_nxt;
            r_cnt   <= w_cnt_nxt;
            r_sel   <= w_sel_nxt;
        end
    end

`ifndef SDRAM_WR_ARB_PRIO_A_EN
    always_ff @(posedge i_clk or negedge i_rst_n) begin
        if (!i_rst_n) begin
            r_last <= SEL_B;
        end else begin
            r_last <= w_last_nxt;
        end
    end
`endif

    sdram_write_mux #(
        .DATA_W (DATA_W),
        .ADDR_W (ADDR_W)
    ) u_mux (
        .i_sel          (r_sel),
        .i_grantA       (w_grantA),
        .i_grantB       (w_grantB),
        .i_dataA        (i_dataA),
        .i_dataB        (i_dataB),
        .i_addrA        (i_addrA),
        .i_addrB        (i_addrB),
        .i_enableWriteA (i_enableWriteA),
        .i_enableWriteB (i_enableWriteB),
        .o_data         (o_data),
        .o_addr         (o_addr),
        .o_enableWrite  (o_enableWrite)
    );

    assign o_grantA = w_grantA;
    assign o_grantB = w_grantB;
    assign o_ackA   = w_beatA;
    assign o_ackB   = w_beatB;
    assign o_sel    = r_sel;
    assign o_busy   = (r_state != IDLE);

endmodule

// File: doc/sdram_write_arbiter.md
Name: sdram_write_arbiter

Overview:
- Arbitrates the shared SDRAM write port between two streaming write requesters: A = layer output writer, B = feature-map spill writer.
- Grants ownership in bounded bursts and drives the A/B select for the write data/address/enable mux.
- Gates the write enable so only the owning requester reaches the SDRAM controller, and returns per-requester beat acknowledges.
- Sits between the compute-side writers and the SDRAM controller write interface.

Parameters:
- DATA_W, 16, write data width
- ADDR_W, 19, SDRAM word address width
- MAX_BURST, 64, maximum beats accepted per grant before forced release; legal range 1..256
- CNT_W, $clog2(MAX_BURST)+1, burst counter width (derived)

Ports:
- i_clk  in  1  system clock; all state on rising edge
- i_rst_n  in  1  asynchronous active-low reset
- i_reqA  in  1  requester A wants the port; held until its burst is done
- i_reqB  in  1  requester B wants the port
- i_dataA  in  DATA_W  A write data
- i_dataB  in  DATA_W  B write data
- i_addrA  in  ADDR_W  A write address
- i_addrB  in  ADDR_W  B write address
- i_enableWriteA  in  1  A beat valid
- i_enableWriteB  in  1  B beat valid
- i_sdramReady  in  1  controller accepts a beat this cycle
- o_grantA  out  1  A owns the port (registered)
- o_grantB  out  1  B owns the port (registered)
- o_ackA  out  1  A beat accepted this cycle
- o_ackB  out  1  B beat accepted this cycle
- o_sel  out  1  mux select; 0 = A, 1 = B (registered)
- o_data  out  DATA_W  muxed write data
- o_addr  out  ADDR_W  muxed write address
- o_enableWrite  out  1  gated write enable to controller
- o_busy  out  1  state != IDLE

Behaviour:
- Clock and reset: one clock, i_clk. Reset i_rst_n is asynchronous and active-low.
- Reset values: state=IDLE; o_grantA=0, o_grantB=0, o_sel=0, o_busy=0; burst counter=0; lastServed=B, so A wins the first tie.
- Reset asserted mid-burst: the burst is dropped immediately and o_enableWrite goes to 0 asynchronously through the grant gating. Requesters re-request after reset.
- States: IDLE, OWN_A, OWN_B.
- IDLE transitions:
  - reqA only -> OWN_A.
  - reqB only -> OWN_B.
  - reqA and reqB -> the requester that is not lastServed.
  - Neither -> stay in IDLE.
  - Grant and o_sel are registered, so a request seen at edge n gives the grant during cycle n+1.
- OWN_X datapath: o_sel held. o_data, o_addr and o_enableWrite come combinationally from the X inputs. o_enableWrite = grantX & i_enableWriteX.
- Beat accepted: grantX & i_enableWriteX & i_sdramReady. The accepted beat drives o_ackX high the same cycle (combinational) and increments the counter.
- OWN_X exit to IDLE, taken at the next edge; on exit lastServed<=X and the counter clears:
  - (a) an accepted beat brings the counter to MAX_BURST, or
  - (b) i_reqX is low.
- A beat accepted in the same cycle that reqX drops is still valid and acked.
- Handover: every owner change passes through one IDLE cycle. There are no back-to-back beats from different requesters, and one gap cycle is guaranteed.
- A requester still asserting req after forced release re-competes in IDLE. Round robin hands the port to the other requester if it is waiting, otherwise back to the same one.
- Non-owner behaviour:
  - ackY = 0.
  - An i_enableWriteY without grant is ignored; no beat is lost at the SDRAM, the requester simply waits.
- i_sdramReady low: beats stall, the counter holds, ownership is kept (no timeout).
- Counter: CNT_W bits, never exceeds MAX_BURST.

Optional Feature:
- Macro: SDRAM_WR_ARB_PRIO_A_EN.
- Defined: the IDLE tie-break always picks A (strict priority); lastServed is ignored. B is still bounded by MAX_BURST, so A waits at most MAX_BURST beats plus 1 cycle.
- Undefined: round robin via lastServed, as above.

Decomposition:
- Package sdram_wr_arb_pkg: state enum (IDLE, OWN_A, OWN_B), SEL_A/SEL_B constants, DATA_W/ADDR_W defaults.
- Sub-module sdram_write_mux: pure 2:1 mux of data, address and enable, driven by o_sel with enable gated by grant. The FSM and counter stay in the top.

Test Plan:
- Reset, then reqA=1 with continuous enA and ready -> grantA=1 in the 2nd cycle. 64 acks, then grantA=0 for 1 cycle, then regrant to A (B idle).
- reqA=reqB=1 from reset, both streaming -> A gets 64 beats, 1 gap cycle, B gets 64 beats, then A again. o_sel toggles 0->1->0, and o_enableWrite is never high in the gap cycle.
- A owns, i_sdramReady low for 10 cycles mid-burst -> no acks, counter frozen at its value, grant held; burst completes at exactly 64 total acks.
- A owns after 5 beats; reqA drops in a cycle with an accepted beat -> 6 acks total, IDLE next cycle, waiting B granted the cycle after.
- i_rst_n pulsed low during a B burst at beat 20 -> grantB and o_enableWrite go 0 immediately. After release with both requesting, A is granted first.
- With SDRAM_WR_ARB_PRIO_A_EN defined, reqA and reqB both high at every IDLE -> A always granted; B is granted only in idles when reqA=0.
